// File: rtl/compare_pkg.sv
// compare_pkg: shared types and opcode decode for the compare scheduler.
// Revision 1.0
`default_nettype none

package compare_pkg;

  localparam int RSP_ID_W = 4;

  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_NE = 2'd1,
    CMP_LT = 2'd2,
    CMP_GE = 2'd3
  } cmp_op_t;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  typedef struct packed {
    logic [RSP_ID_W-1:0] id;
    logic                result;
    logic                eq;
    logic                lt;
  } rsp_t;

  function automatic logic op_result(input cmp_op_t op, input logic eq, input logic lt);
    logic r;
    case (op)
      CMP_EQ:  r = eq;
      CMP_NE:  r = ~eq;
      CMP_LT:  r = lt;
      default: r = ~lt;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/comparator_eq.sv
// comparator_eq: N-bit equality compare.
// Revision 1.0
`default_nettype none

module comparator_eq #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         eq
);

  assign eq = (a == b);

endmodule

`default_nettype wire

// File: rtl/comparator_lt.sv
// comparator_lt: N-bit two's-complement signed less-than.
// Revision 1.0
`default_nettype none

module comparator_lt #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt
);

  assign lt = ($signed(a) < $signed(b));

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request at or after ptr, wrapping.
// Revision 1.0
`default_nettype none

module rr_arbiter #(
  parameter int M    = 4,
  parameter int ID_W = $clog2(M)
) (
  input  logic [M-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            enable,
  output logic [M-1:0]    grant,
  output logic [ID_W-1:0] grant_idx
);

  logic            found;
  logic [ID_W:0]   sum;
  logic [ID_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < M; k++) begin
      // Wide sum keeps the wrap correct when M is not a power of two.
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(M)) sum = sum - (ID_W+1)'(M);
      cand = sum[ID_W-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (enable && found) grant[grant_idx] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/compare_scheduler.sv
// compare_scheduler: round-robin time-sharing of one signed eq/lt comparator
// pair among M requesters, with a single registered response slot. Revision 1.0
`default_nettype none

module compare_scheduler
  import compare_pkg::*;
#(
  parameter int N    = 32,
  parameter int M    = 4,
  parameter int ID_W = $clog2(M)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [M-1:0]      req_valid,
  output logic [M-1:0]      req_ready,
  input  logic [M*N-1:0]    req_a,
  input  logic [M*N-1:0]    req_b,
  input  logic [M*2-1:0]    req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic              rsp_result,
  output logic              rsp_eq,
  output logic              rsp_lt
);

  slot_state_t     state;
  logic [ID_W-1:0] rr_ptr;
  rsp_t            slot;
  rsp_t            rsp_d;

  logic            can_accept;
  logic            accept;
  logic [M-1:0]    grant;
  logic [ID_W-1:0] grant_idx;
  logic [N-1:0]    a_sel;
  logic [N-1:0]    b_sel;
  logic [1:0]      op_sel;
  logic            eq;
  logic            lt;

  // rsp_ready reaches only req_ready; responses come straight from the slot.
  assign can_accept = (state == SLOT_EMPTY) || rsp_ready;

  rr_arbiter #(.M(M), .ID_W(ID_W)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .enable    (can_accept && rst_n),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);

  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = '0;
    for (int i = 0; i < M; i++) begin
      if (grant_idx == ID_W'(i)) begin
        a_sel  = req_a[i*N +: N];
        b_sel  = req_b[i*N +: N];
        op_sel = req_op[i*2 +: 2];
      end
    end
  end

  comparator_eq #(.N(N)) u_eq (.a(a_sel), .b(b_sel), .eq(eq));
  comparator_lt #(.N(N)) u_lt (.a(a_sel), .b(b_sel), .lt(lt));

  always_comb begin
    rsp_d        = '0;
    rsp_d.id     = RSP_ID_W'(grant_idx);
    rsp_d.eq     = eq;
    rsp_d.lt     = lt;
    rsp_d.result = op_result(cmp_op_t'(op_sel), eq, lt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= SLOT_EMPTY;
      rr_ptr <= '0;
      slot   <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: if (accept) state <= SLOT_FULL;
        SLOT_FULL:  if (rsp_ready && !accept) state <= SLOT_EMPTY;
        default:    state <= SLOT_EMPTY;
      endcase
      if (accept) begin
        slot   <= rsp_d;
        rr_ptr <= (grant_idx == ID_W'(M-1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  assign rsp_valid  = (state == SLOT_FULL);
  assign rsp_id     = ID_W'(slot.id);
  assign rsp_result = slot.result;
  assign rsp_eq     = slot.eq;
  assign rsp_lt     = slot.lt;

endmodule

`default_nettype wire

// File: tb/tb_compare_scheduler.sv
// tb_compare_scheduler: scoreboard bench with an independent round-robin model.
// Revision 1.0
`default_nettype none

module tb_compare_scheduler;

  localparam int N    = 32;
  localparam int M    = 4;
  localparam int ID_W = $clog2(M);

  logic              clk;
  logic              rst_n;
  logic [M-1:0]      req_valid;
  logic [M-1:0]      req_ready;
  logic [M*N-1:0]    req_a;
  logic [M*N-1:0]    req_b;
  logic [M*2-1:0]    req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_result;
  logic              rsp_eq;
  logic              rsp_lt;

  compare_scheduler #(.N(N), .M(M), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_eq     (rsp_eq),
    .rsp_lt     (rsp_lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    bit result;
    bit eq;
    bit lt;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   model_ptr;
  int   n_checks;
  int   n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t model(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [1:0] op);
    exp_t e;
    e.id = id;
    e.eq = (a == b);
    e.lt = ($signed(a) < $signed(b));
    case (op)
      2'd0:    e.result = e.eq;
      2'd1:    e.result = !e.eq;
      2'd2:    e.result = e.lt;
      default: e.result = !e.lt;
    endcase
    return e;
  endfunction

  // Reference model: runs mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_req_ready", 64'(req_ready), 64'd0);
      sb.delete();
      model_ptr = 0;
    end else begin
      bit full;
      bit can;
      int g;
      exp_t e;
      full = (sb.size() != 0);
      check("rsp_valid", 64'(rsp_valid), 64'(full));
      if (full && rsp_valid) begin
        e = sb[0];
        check("rsp_id", 64'(rsp_id), 64'(e.id));
        check("rsp_result", 64'(rsp_result), 64'(e.result));
        check("rsp_eq", 64'(rsp_eq), 64'(e.eq));
        check("rsp_lt", 64'(rsp_lt), 64'(e.lt));
      end
      if (full && rsp_ready) void'(sb.pop_front());
      can = !full || rsp_ready;
      g = -1;
      if (can) begin
        for (int k = 0; k < M; k++) begin
          int idx;
          idx = (model_ptr + k) % M;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      check("req_ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
      if (g >= 0) begin
        sb.push_back(model(g, req_a[g*N +: N], req_b[g*N +: N], req_op[g*2 +: 2]));
        model_ptr = (g + 1) % M;
      end
      for (int i = 0; i < M; i++) if (req_ready[i]) grant_log.push_back(i);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [1:0] op);
    req_valid[i]     = v;
    req_a[i*N +: N]  = a;
    req_b[i*N +: N]  = b;
    req_op[i*2 +: 2] = op;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    rsp_ready = 1'b1;
    step(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[5];
    bit seen;
    n_checks  = 0;
    n_pass    = 0;
    model_ptr = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    step(2);
    check("reset_rsp_id", 64'(rsp_id), 64'd0);
    check("reset_rsp_bits", {61'd0, rsp_result, rsp_eq, rsp_lt}, 64'd0);
    rst_n = 1'b1;
    step(1);

    // All four valid: expect strict rotation 0,1,2,3,0.
    for (int i = 0; i < M; i++) set_req(i, 1, 32'(i * 7), 32'(20 - i * 5), 2'(i));
    grant_log.delete();
    step(5);
    exp_order = '{0, 1, 2, 3, 0};
    check("rotation_len", 64'(grant_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check("rotation_id", 64'(grant_log[i]), 64'(exp_order[i]));
    idle(3);

    // Requester 2 alone: -1 < 1.
    set_req(2, 1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2);
    @(negedge clk); #1;
    check("r2_ready", 64'(req_ready), 64'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk); #1;
    check("r2_rsp", {60'd0, rsp_valid, rsp_result, rsp_lt, rsp_eq}, 64'b1110);
    idle(2);

    // Opcode sweep plus signed edge cases.
    for (int op = 0; op < 4; op++) begin
      set_req(1, 1, 32'd38273, 32'd38273, 2'(op));
      step(1);
    end
    set_req(1, 1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'd3);
    step(1);
    set_req(1, 1, 32'h8000_0000, 32'h7FFF_FFFF, 2'd2);
    step(1);
    set_req(1, 1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2);
    step(1);
    idle(3);

    // Backpressure: one response held, nothing accepted, then drain + accept.
    set_req(0, 1, 32'd5, 32'd9, 2'd2);
    set_req(1, 1, 32'd9, 32'd5, 2'd3);
    rsp_ready = 1'b0;
    step(6);
    rsp_ready = 1'b1;
    step(3);
    idle(3);

    // Fairness: requester 3 joins a stream from requester 0.
    set_req(0, 1, 32'd1, 32'd1, 2'd0);
    step(10);
    set_req(3, 1, 32'd2, 32'd3, 2'd1);
    seen = 1'b0;
    for (int c = 0; c < M && !seen; c++) begin
      @(negedge clk); #1;
      if (req_ready[3]) seen = 1'b1;
    end
    check("fair_r3_granted", 64'(seen), 64'd1);
    step(6);
    idle(3);

    // Asynchronous reset while FULL under backpressure.
    set_req(3, 1, 32'd4, 32'd4, 2'd0);
    rsp_ready = 1'b0;
    step(3);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rsp_valid", 64'(rsp_valid), 64'd0);
    check("async_req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    set_req(1, 1, 32'd3, 32'd8, 2'd2);
    set_req(2, 1, 32'd8, 32'd3, 2'd2);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("post_reset_grant", 64'(req_ready), 64'b0010);
    step(4);
    idle(4);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
